video_timing_meter: RTL

Passive receiver for the CRTC video timing interface: samples `h_sync`, `v_sync` and `de` on character-clock enables and recovers the frame geometry (line period, sync widths, displayed width/height, lines per frame). Sits beside the CRTC and video output path. Software uses it for display-mode detection; the bench uses it to self-check the timing generator.

---
 rtl/video_timing_meter.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/video_timing_meter.sv
// video_timing_meter: passive monitor of the CRTC timing outputs.
// Samples h_sync / v_sync / de on character-clock ticks and recovers the
// frame geometry (line period, sync widths, displayed area, lines per frame).
// A publish happens on every v_sync rising edge once a full frame is measured.
// Optional feature: define VIDEO_TIMING_METER_LOCK_EN to compare each publish
// against the previous one and report geometry stability on locked_o;
// otherwise locked_o simply mirrors valid_o.
module video_timing_meter (
  input  logic       wb_clock_i,
  input  logic       reset_i,
  input  logic       clk_en_i,
  input  logic       h_sync_i,
  input  logic       v_sync_i,
  input  logic       de_i,
  output logic [8:0] h_total_o,
  output logic [4:0] h_sync_width_o,
  output logic [8:0] h_de_o,
  output logic [9:0] v_total_o,
  output logic [4:0] v_sync_width_o,
  output logic [9:0] v_de_o,
  output logic       valid_o,
  output logic       locked_o,
  output logic       update_o
);

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_MEASURE = 2'd1,
    S_VALID   = 2'd2
  } state_t;

  // The six published fields travel together as one record.
  typedef struct packed {
    logic [8:0] h_total;
    logic [4:0] h_sync_width;
    logic [8:0] h_de;
    logic [9:0] v_total;
    logic [4:0] v_sync_width;
    logic [9:0] v_de;
  } meas_t;

  localparam logic [8:0] H_MAX  = 9'd511;
  localparam logic [4:0] W_MAX  = 5'd31;
  localparam logic [9:0] V_MAX  = 10'd1023;

  // Previous-tick samples for edge detection.
  logic hs_q, hs_d, vs_q, vs_d;

  // Horizontal counters and their per-line captures.
  logic [8:0] h_cnt_q, h_cnt_d;
  logic [4:0] hs_cnt_q, hs_cnt_d;
  logic [8:0] de_cnt_q, de_cnt_d;
  logic [8:0] h_period_q, h_period_d;
  logic [4:0] hs_width_q, hs_width_d;
  logic [8:0] h_de_width_q, h_de_width_d;

  // Vertical counters (advanced on h_sync rising edges) and captures.
  logic [9:0] line_cnt_q, line_cnt_d;
  logic [9:0] de_line_cnt_q, de_line_cnt_d;
  logic       line_de_q, line_de_d;
  logic [4:0] vs_cnt_q, vs_cnt_d;
  logic [4:0] vs_width_q, vs_width_d;

  // Control and published results.
  state_t state_q, state_d;
  logic   publish;
  meas_t  meas_new, meas_q, meas_d;
  logic   valid_q, valid_d;
  logic   update_q, update_d;

  logic tick, h_rise, h_fall, v_rise, v_fall, timeout;

  assign tick    = clk_en_i;
  assign h_rise  = tick &  h_sync_i & ~hs_q;
  assign h_fall  = tick & ~h_sync_i &  hs_q;
  assign v_rise  = tick &  v_sync_i & ~vs_q;
  assign v_fall  = tick & ~v_sync_i &  vs_q;
  // A stalled line or frame counter means the timing source has gone away.
  assign timeout = tick & ((h_cnt_q == H_MAX) | (line_cnt_q == V_MAX));

  assign meas_new = {h_period_q, hs_width_q, h_de_width_q,
                     line_cnt_q, vs_width_q, de_line_cnt_q};

  // Next-state for edge samples and all measurement counters.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    hs_d          = hs_q;
    vs_d          = vs_q;
    h_cnt_d       = h_cnt_q;
    hs_cnt_d      = hs_cnt_q;
    de_cnt_d      = de_cnt_q;
    h_period_d    = h_period_q;
    hs_width_d    = hs_width_q;
    h_de_width_d  = h_de_width_q;
    line_cnt_d    = line_cnt_q;
    de_line_cnt_d = de_line_cnt_q;
    line_de_d     = line_de_q;
    vs_cnt_d      = vs_cnt_q;
    vs_width_d    = vs_width_q;

    if (tick) begin
      hs_d = h_sync_i;
      vs_d = v_sync_i;

      // Line period: ticks between consecutive h_sync rising edges.
      if (h_rise) begin
        h_period_d = h_cnt_q;
        h_cnt_d    = 9'd1;
      end else if (h_cnt_q != H_MAX) begin
        h_cnt_d = h_cnt_q + 9'd1;
      end

      // h_sync pulse width, captured when the pulse ends.
      if (h_rise) begin
        hs_cnt_d = 5'd1;
      end else if (h_sync_i && (hs_cnt_q != W_MAX)) begin
        hs_cnt_d = hs_cnt_q + 5'd1;
      end
      if (h_fall) hs_width_d = hs_cnt_q;

      // Displayed width; lines without any de keep the last non-blank value.
      if (h_rise) begin
        if (de_cnt_q != 9'd0) h_de_width_d = de_cnt_q;
        de_cnt_d = {8'd0, de_i};
      end else if (de_i && (de_cnt_q != H_MAX)) begin
        de_cnt_d = de_cnt_q + 9'd1;
      end

      // Line counting; the current tick's de belongs to the line just starting.
      if (h_rise) begin
        if (line_cnt_q != V_MAX) line_cnt_d = line_cnt_q + 10'd1;
        if (line_de_q && (de_line_cnt_q != V_MAX)) de_line_cnt_d = de_line_cnt_q + 10'd1;
        line_de_d = de_i;
      end else if (de_i) begin
        line_de_d = 1'b1;
      end

      // v_sync width in lines, captured when the pulse ends.
      if (h_rise && v_sync_i && (vs_cnt_q != W_MAX)) vs_cnt_d = vs_cnt_q + 5'd1;
      if (v_fall) vs_width_d = vs_cnt_q;

      // Frame boundary: a line that ends on this very tick opens the new frame.
      if (v_rise) begin
        line_cnt_d    = h_rise ? 10'd1 : 10'd0;
        de_line_cnt_d = (h_rise && line_de_q) ? 10'd1 : 10'd0;
        vs_cnt_d      = h_rise ? 5'd1 : 5'd0;
      end
    end
  end

  // Counter and capture registers.
  always_ff @(posedge wb_clock_i or posedge reset_i) begin
    if (reset_i) begin
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      h_cnt_q       <= 9'd0;
      hs_cnt_q      <= 5'd0;
      de_cnt_q      <= 9'd0;
      h_period_q    <= 9'd0;
      hs_width_q    <= 5'd0;
      h_de_width_q  <= 9'd0;
      line_cnt_q    <= 10'd0;
      de_line_cnt_q <= 10'd0;
      line_de_q     <= 1'b0;
      vs_cnt_q      <= 5'd0;
      vs_width_q    <= 5'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      h_cnt_q       <= h_cnt_d;
      hs_cnt_q      <= hs_cnt_d;
      de_cnt_q      <= de_cnt_d;
      h_period_q    <= h_period_d;
      hs_width_q    <= hs_width_d;
      h_de_width_q  <= h_de_width_d;
      line_cnt_q    <= line_cnt_d;
      de_line_cnt_q <= de_line_cnt_d;
      line_de_q     <= line_de_d;
      vs_cnt_q      <= vs_cnt_d;
      vs_width_q    <= vs_width_d;
    end
  end

  // Frame-level sequencing: skip the first partial frame, then publish per v-edge.
  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    if (timeout) begin
      state_d = S_WAIT;
    end else if (v_rise) begin
      case (state_q)
        S_WAIT:    state_d = S_MEASURE;
        S_MEASURE: begin
          publish = 1'b1;
          state_d = S_VALID;
        end
        S_VALID:   publish = 1'b1;
        default:   state_d = S_WAIT;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge wb_clock_i or posedge reset_i) begin
    if (reset_i) state_q <= S_WAIT;
    else         state_q <= state_d;
  end

  // Published results: load on publish, clear on timeout.
  always_comb begin
    meas_d   = meas_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    if (timeout) begin
      meas_d  = '0;
      valid_d = 1'b0;
    end else if (publish) begin
      meas_d   = meas_new;
      valid_d  = 1'b1;
      update_d = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge wb_clock_i or posedge reset_i) begin
    if (reset_i) begin
      meas_q   <= '0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
    end else begin
      meas_q   <= meas_d;
      valid_q  <= valid_d;
      update_q <= update_d;
    end
  end

`ifdef VIDEO_TIMING_METER_LOCK_EN
  meas_t shadow_q, shadow_d;
  logic  locked_q, locked_d;

  // Stability check: a publish in VALID that repeats the previous one locks.
  always_comb begin
    shadow_d = shadow_q;
    locked_d = locked_q;
    if (timeout) begin
      shadow_d = '0;
      locked_d = 1'b0;
    end else if (publish) begin
      shadow_d = meas_new;
      locked_d = (state_q == S_VALID) && (meas_new == shadow_q);
    end
  end

  // Shadow and lock registers.
  always_ff @(posedge wb_clock_i or posedge reset_i) begin
    if (reset_i) begin
      shadow_q <= '0;
      locked_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      locked_q <= locked_d;
    end
  end

  assign locked_o = locked_q;
`else
  assign locked_o = valid_q;
`endif

  assign h_total_o      = meas_q.h_total;
  assign h_sync_width_o = meas_q.h_sync_width;
  assign h_de_o         = meas_q.h_de;
  assign v_total_o      = meas_q.v_total;
  assign v_sync_width_o = meas_q.v_sync_width;
  assign v_de_o         = meas_q.v_de;
  assign valid_o        = valid_q;
  assign update_o       = update_q;

endmodule
